frame_buffer_reader: RTL and testbench

//  Read side of the 320x240 RGB565 frame buffer. The filter chain writes pixels into the buffer.

---
 rtl/frame_buffer_reader.sv | 176 +++++++++++++++++
 tb/tb_frame_buffer_reader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_reader.sv
// -----------------------------------------------------------------------------
// frame_buffer_reader
//
// Read side of the IMG_WIDTH x IMG_HEIGHT RGB565 frame buffer. The block
// generates VGA timing from the pixel clock. It reads the buffer with 2x pixel
// and 2x line replication, so each buffer pixel covers a 2x2 block on screen.
// It drives sync, DE and RGB444 to the pins. All of these outputs are aligned
// to the read data.
//
// Ports
//   clk            in   1   pixel clock
//   reset          in   1   synchronous, active-high reset
//   o_re           out  1   frame buffer read enable
//   o_rAddr        out  17  frame buffer read address
//   i_rData        in   16  RGB565 read data, valid RD_LAT cycles after o_re
//   o_hsync        out  1   horizontal sync, active low
//   o_vsync        out  1   vertical sync, active low
//   o_de           out  1   display enable
//   o_red/green/blue out 4  RGB444 pixel, black while o_de=0
//   o_frame_start  out  1   one-cycle pulse on output pixel (0,0)
//
// Optional feature macro: FB_READER_BORDER_EN
//   When this macro is defined, the first and last active column and row are
//   forced to white. Read enable and read address are not affected.
// -----------------------------------------------------------------------------
module frame_buffer_reader #(
   parameter int IMG_WIDTH  = 320,
   parameter int IMG_HEIGHT = 240,
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter int RD_LAT     = 1
) (
   input  logic        clk,
   input  logic        reset,
   output logic        o_re,
   output logic [16:0] o_rAddr,
   input  logic [15:0] i_rData,
   output logic        o_hsync,
   output logic        o_vsync,
   output logic        o_de,
   output logic [3:0]  o_red,
   output logic [3:0]  o_green,
   output logic [3:0]  o_blue,
   output logic        o_frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   // The pipeline has one stage for the read issue, plus RD_LAT stages of buffer latency.
   localparam int PD      = RD_LAT + 1;

   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);

   logic [HW-1:0] h_cnt_q, h_cnt_d;
   logic [VW-1:0] v_cnt_q, v_cnt_d;
   logic [16:0]   raddr_q, raddr_d;
   logic [16:0]   row_base;
   logic [PD-1:0] de_pipe_q, de_pipe_d;
   logic [PD-1:0] hs_pipe_q, hs_pipe_d;
   logic [PD-1:0] vs_pipe_q, vs_pipe_d;
   logic [PD-1:0] fs_pipe_q, fs_pipe_d;
   logic          active, hs, vs, first_px;
`ifdef FB_READER_BORDER_EN
   logic [PD-1:0] bd_pipe_q, bd_pipe_d;
   logic          border;
`endif

   // RGB565 low bits are dropped when the data is reduced to RGB444.
   logic unused_bits;
   assign unused_bits = ^{i_rData[11], i_rData[6:5], i_rData[0], 32'(IMG_HEIGHT)};

   always_comb begin
      h_cnt_d = h_cnt_q + HW'(1);
      v_cnt_d = v_cnt_q;
      if (h_cnt_q == H_LAST) begin
         h_cnt_d = '0;
         if (v_cnt_q == V_LAST) v_cnt_d = '0;
         else                   v_cnt_d = v_cnt_q + VW'(1);
      end
   end

   // ---- stage 0: decode from counters; stage 1 .. PD: delay line ----
   always_comb begin
      active   = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
      hs       = !((h_cnt_q >= H_SS) && (h_cnt_q < H_SE));
      vs       = !((v_cnt_q >= V_SS) && (v_cnt_q < V_SE));
      first_px = (h_cnt_q == '0) && (v_cnt_q == '0);

      // Dropping the low bit of each counter repeats every address on two
      // pixels and two lines. There is no line buffer, so the row is re-read.
      row_base = 17'(v_cnt_q >> 1) * 17'(IMG_WIDTH);
      raddr_d  = raddr_q;
      if (active) raddr_d = row_base + 17'(h_cnt_q >> 1);

      de_pipe_d = {de_pipe_q[PD-2:0], active};
      hs_pipe_d = {hs_pipe_q[PD-2:0], hs};
      vs_pipe_d = {vs_pipe_q[PD-2:0], vs};
      fs_pipe_d = {fs_pipe_q[PD-2:0], first_px};
`ifdef FB_READER_BORDER_EN
      border    = active && ((h_cnt_q == '0) || (h_cnt_q == H_ACT - HW'(1)) ||
                             (v_cnt_q == '0) || (v_cnt_q == V_ACT - VW'(1)));
      bd_pipe_d = {bd_pipe_q[PD-2:0], border};
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         h_cnt_q   <= '0;
         v_cnt_q   <= '0;
         raddr_q   <= '0;
         de_pipe_q <= '0;
         hs_pipe_q <= '1;
         vs_pipe_q <= '1;
         fs_pipe_q <= '0;
`ifdef FB_READER_BORDER_EN
         bd_pipe_q <= '0;
`endif
      end else begin
         h_cnt_q   <= h_cnt_d;
         v_cnt_q   <= v_cnt_d;
         raddr_q   <= raddr_d;
         de_pipe_q <= de_pipe_d;
         hs_pipe_q <= hs_pipe_d;
         vs_pipe_q <= vs_pipe_d;
         fs_pipe_q <= fs_pipe_d;
`ifdef FB_READER_BORDER_EN
         bd_pipe_q <= bd_pipe_d;
`endif
      end
   end

   // Stage 1 of the pipeline is also the read issue.
   assign o_re          = de_pipe_q[0];
   assign o_rAddr       = raddr_q;
   assign o_de          = de_pipe_q[PD-1];
   assign o_hsync       = hs_pipe_q[PD-1];
   assign o_vsync       = vs_pipe_q[PD-1];
   assign o_frame_start = fs_pipe_q[PD-1];

   // ---- output stage: buffer data is valid in the same cycle as the last pipe stage ----
   // The colour is gated directly from i_rData. Registering it would add a
   // cycle that the control path does not have.
   always_comb begin
      o_red   = '0;
      o_green = '0;
      o_blue  = '0;
      if (o_de) begin
         o_red   = i_rData[15:12];
         o_green = i_rData[10:7];
         o_blue  = i_rData[4:1];
`ifdef FB_READER_BORDER_EN
         if (bd_pipe_q[PD-1]) begin
            o_red   = 4'hF;
            o_green = 4'hF;
            o_blue  = 4'hF;
         end
`endif
      end
   end

endmodule

// File: tb/tb_frame_buffer_reader.sv
// Bench for frame_buffer_reader, built with reduced timing so that whole frames run quickly.
// Image 8x6, screen 16x12 active, line 25 cycles, frame 17 lines (425 cycles).
module tb_frame_buffer_reader;

   localparam int IW  = 8;
   localparam int IH  = 6;
   localparam int HA  = 16;
   localparam int HFP = 2;
   localparam int HS  = 4;
   localparam int HBP = 3;
   localparam int VA  = 12;
   localparam int VFP = 1;
   localparam int VS  = 2;
   localparam int VBP = 2;
   localparam int RDL = 1;
   localparam int HT  = HA + HFP + HS + HBP;
   localparam int VT  = VA + VFP + VS + VBP;
   localparam int F   = HT * VT;
   localparam int L   = RDL + 1;
   localparam int MEMN = IW * IH;
`ifdef FB_READER_BORDER_EN
   localparam logic [11:0] BORDER_RGB = 12'hFFF;
`else
   localparam logic [11:0] BORDER_RGB = 12'h000;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        o_re;
   logic [16:0] o_rAddr;
   logic [15:0] i_rData;
   logic        o_hsync, o_vsync, o_de, o_frame_start;
   logic [3:0]  o_red, o_green, o_blue;

   logic [15:0] mem [MEMN];
   logic [15:0] rd_pipe [RDL];

   int n = 0;
   bit model_on = 0;
   bit stats_on = 0;
   bit cap_on = 0;
   int errors = 0;
   int checks = 0;
   int st_de = 0, st_hs = 0, st_vs = 0, st_fs = 0;
   int cap[$];

   frame_buffer_reader #(
      .IMG_WIDTH(IW), .IMG_HEIGHT(IH),
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
      .RD_LAT(RDL)
   ) dut (
      .clk(clk), .reset(reset), .o_re(o_re), .o_rAddr(o_rAddr), .i_rData(i_rData),
      .o_hsync(o_hsync), .o_vsync(o_vsync), .o_de(o_de),
      .o_red(o_red), .o_green(o_green), .o_blue(o_blue), .o_frame_start(o_frame_start)
   );

   always #20 clk = ~clk;

   // Frame buffer model: returns the data RDL cycles after a read. Returns junk when not reading.
   always @(posedge clk) begin
      int ai;
      ai = int'(o_rAddr);
      rd_pipe[0] <= (o_re && ai < MEMN) ? mem[ai] : 16'hDEAD;
      for (int i = 1; i < RDL; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign i_rData = rd_pipe[RDL-1];

   // n is the screen position (as a linear index) that the counters hold in this cycle.
   always @(posedge clk) begin
      if (reset) n <= 0;
      else       n <= n + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at n=%0d: got %0h expected %0h", name, n, act, exp);
      end
   endtask

   function automatic bit is_act(input int k);
      int x, y;
      x = k % HT;
      y = (k / HT) % VT;
      return (x < HA) && (y < VA);
   endfunction

   function automatic int exp_addr(input int k);
      int x, y;
      x = k % HT;
      y = (k / HT) % VT;
      return (y / 2) * IW + x / 2;
   endfunction

   // {re, de, hsync, vsync, frame_start, rgb[11:0]} that the pins must show at position m.
   function automatic logic [16:0] exp_vec(input int m);
      int k, x, y;
      logic re, de, hs, vs, fs;
      logic [15:0] d;
      logic [11:0] rgb;
      re = (m >= 1) && is_act(m - 1);
      if (m < L) return {re, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000};
      k  = m - L;
      x  = k % HT;
      y  = (k / HT) % VT;
      de = (x < HA) && (y < VA);
      hs = !((x >= HA + HFP) && (x < HA + HFP + HS));
      vs = !((y >= VA + VFP) && (y < VA + VFP + VS));
      fs = (x == 0) && (y == 0);
      rgb = 12'h000;
      if (de) begin
         d   = mem[(y / 2) * IW + x / 2];
         rgb = {d[15:12], d[10:7], d[4:1]};
         if (x == 0 || x == HA - 1 || y == 0 || y == VA - 1)
            if (BORDER_RGB != 12'h000) rgb = BORDER_RGB;
      end
      return {re, de, hs, vs, fs, rgb};
   endfunction

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      logic [16:0] ev;
      if (model_on) begin
         ev = exp_vec(n);
         chk("pins", {15'd0, o_re, o_de, o_hsync, o_vsync, o_frame_start, o_red, o_green, o_blue},
             {15'd0, ev});
         if (ev[16]) chk("raddr", {15'd0, o_rAddr}, exp_addr(n - 1));
      end
   end

   always @(negedge clk) begin
      if (stats_on && n >= L && n < L + 2 * F) begin
         st_de = st_de + int'(o_de);
         st_hs = st_hs + int'(!o_hsync);
         st_vs = st_vs + int'(!o_vsync);
         st_fs = st_fs + int'(o_frame_start);
      end
      if (cap_on && o_re && n >= 1 && n <= F) cap.push_back(int'(o_rAddr));
   end

   task automatic fill(input int mode);
      for (int a = 0; a < MEMN; a++)
         mem[a] = (mode == 0) ? 16'(a) : (mode == 1) ? 16'hF800 : 16'h0000;
   endtask

   // Holds reset for two clock edges. The buffer is reloaded only while the outputs are inactive.
   task automatic do_reset(input int mode);
      reset = 1'b1;
      @(negedge clk);
      fill(mode);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      fill(0);
      // T1: reset state
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("rst_pins", {15'd0, o_re, o_de, o_hsync, o_vsync, o_frame_start, o_red, o_green, o_blue},
             {15'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000});
      end
      chk("rst_raddr", {15'd0, o_rAddr}, 32'd0);
      reset = 1'b0;
      model_on = 1;
      stats_on = 1;
      cap_on = 1;
      repeat (L - 1) @(negedge clk);
      chk("t1_de_early", {31'd0, o_de}, 32'd0);
      chk("t1_re_first", {31'd0, o_re}, 32'd1);
      @(negedge clk);
      chk("t1_de_first", {31'd0, o_de}, 32'd1);
      chk("t1_fs_first", {31'd0, o_frame_start}, 32'd1);

      // T2/T3: two whole frames, address pattern buffer
      repeat (2 * F + 3) @(negedge clk);
      stats_on = 0;
      cap_on = 0;
      chk("t2_de_cnt", st_de, 32'd384);
      chk("t2_hs_low", st_hs, 32'd136);
      chk("t2_vs_low", st_vs, 32'd100);
      chk("t2_fs_cnt", st_fs, 32'd2);
      chk("t3_nreads", cap.size(), 32'd192);
      if (cap.size() >= 192) begin
         chk("t3_a0", cap[0], 32'd0);
         chk("t3_a1", cap[1], 32'd0);
         chk("t3_a2", cap[2], 32'd1);
         chk("t3_a15", cap[15], 32'd7);
         chk("t3_line1", cap[16], 32'd0);
         chk("t3_line2", cap[32], 32'd8);
         chk("t3_last", cap[191], 32'd47);
      end

      // T4: constant red buffer, blanking and sync alignment
      do_reset(1);
      repeat (L + 16) @(negedge clk);
      chk("t4_blank_rgb", {20'd0, o_red, o_green, o_blue}, 32'h000);
      chk("t4_blank_de", {31'd0, o_de}, 32'd0);
      @(negedge clk);
      chk("t4_hs_before", {31'd0, o_hsync}, 32'd1);
      @(negedge clk);
      chk("t4_hs_fall", {31'd0, o_hsync}, 32'd0);
      repeat (62) @(negedge clk);
      chk("t4_red", {20'd0, o_red, o_green, o_blue}, 32'hF00);

      // T5: one-cycle reset at line 10, pixel 5
      repeat (255 - (L + 80)) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("t5_de_rst", {31'd0, o_de}, 32'd0);
      repeat (L - 1) @(negedge clk);
      chk("t5_de_early", {31'd0, o_de}, 32'd0);
      chk("t5_fs_early", {31'd0, o_frame_start}, 32'd0);
      @(negedge clk);
      chk("t5_fs", {31'd0, o_frame_start}, 32'd1);
      chk("t5_de", {31'd0, o_de}, 32'd1);

      // T6: black buffer, border columns/rows
      do_reset(2);
      repeat (L) @(negedge clk);
      chk("t6_px_0_0", {20'd0, o_red, o_green, o_blue}, {20'd0, BORDER_RGB});
      repeat (53) @(negedge clk);
      chk("t6_px_3_2", {20'd0, o_red, o_green, o_blue}, 32'h000);
      repeat (87) @(negedge clk);
      chk("t6_px_15_5", {20'd0, o_red, o_green, o_blue}, {20'd0, BORDER_RGB});
      repeat (140) @(negedge clk);
      chk("t6_px_5_11", {20'd0, o_red, o_green, o_blue}, {20'd0, BORDER_RGB});
      repeat (F) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
